// File: rtl/serial_subtractor8.sv
// Bit-serial 8-bit subtractor, LSB first, one bit per clock; D = A - B - Bin.
// Optional macro SUB_OVF_EN adds a registered signed-overflow output Ovf.
module serial_subtractor8 (
  input  logic       Clk,
  input  logic       RstN,
  input  logic       Start,
  input  logic       Bin,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] D,
  output logic       Bout
`ifdef SUB_OVF_EN
  ,
  output logic       Ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic        br_r;
  logic [2:0]  cnt_r;
  logic [6:0]  diff_sh_r;
  logic        d_bit_s;
  logic        br_next_s;

  function automatic logic diff_bit(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic borrow_next(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  // Full-subtractor cell for the operand bit currently at position 0
  always_comb begin
    d_bit_s   = diff_bit(a_r[0], b_r[0], br_r);
    br_next_s = borrow_next(a_r[0], b_r[0], br_r);
  end

  // Control FSM, operand/borrow shift registers and registered result outputs
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r   <= IDLE;
      a_r       <= 8'h00;
      b_r       <= 8'h00;
      br_r      <= 1'b0;
      cnt_r     <= 3'd0;
      diff_sh_r <= 7'h00;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      D         <= 8'h00;
      Bout      <= 1'b0;
`ifdef SUB_OVF_EN
      Ovf       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_r     <= A;
            b_r     <= B;
            br_r    <= Bin;
            cnt_r   <= 3'd0;
            Busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            Busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_r       <= {1'b0, a_r[7:1]};
          b_r       <= {1'b0, b_r[7:1]};
          br_r      <= br_next_s;
          diff_sh_r <= {d_bit_s, diff_sh_r[6:1]};
          // Counter wraps 7 -> 0 on the same edge that publishes the result
          cnt_r     <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            D       <= {d_bit_s, diff_sh_r};
            Bout    <= br_next_s;
`ifdef SUB_OVF_EN
            Ovf     <= br_r ^ br_next_s;
`endif
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            Done    <= 1'b0;
            Busy    <= 1'b1;
            state_r <= SHIFT;
          end
        end
        DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed bench for serial_subtractor8: cycle-exact Busy/Done timing, result
// values, ignored Start in SHIFT/DONE, and asynchronous reset mid-operation.
module tb_serial_subtractor8;

  logic       Clk;
  logic       RstN;
  logic       Start;
  logic       Bin;
  logic [7:0] A;
  logic [7:0] B;
  logic       Busy;
  logic       Done;
  logic [7:0] D;
  logic       Bout;
`ifdef SUB_OVF_EN
  logic       Ovf;
`endif

  int n_checks;
  int n_fails;
  logic [7:0] exp_d;
  logic       exp_b;

  serial_subtractor8 dut (
    .Clk   (Clk),
    .RstN  (RstN),
    .Start (Start),
    .Bin   (Bin),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .D     (D),
    .Bout  (Bout)
`ifdef SUB_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // One operation; inj>0 re-asserts Start (A=FF) after edge k+inj for one cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo, input int inj);
    $display("op %02h - %02h - %0b : expect D=%02h Bout=%0b Ovf=%0b", a, b, bin, ed, eb, eo);
    @(negedge Clk);
    Start = 1'b1; A = a; B = b; Bin = bin;
    @(posedge Clk); #1;
    check("busy_k", {31'd0, Busy}, 32'd1);
    check("done_k", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Start = 1'b0; A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
    for (int e = 1; e <= 9; e++) begin
      @(posedge Clk); #1;
      if (e <= 7) begin
        check("busy_shift", {31'd0, Busy}, 32'd1);
        check("done_shift", {31'd0, Done}, 32'd0);
        check("d_hold", {24'd0, D}, {24'd0, exp_d});
        check("bout_hold", {31'd0, Bout}, {31'd0, exp_b});
      end else if (e == 8) begin
        check("done_pulse", {31'd0, Done}, 32'd1);
        check("busy_end", {31'd0, Busy}, 32'd0);
        check("d_result", {24'd0, D}, {24'd0, ed});
        check("bout_result", {31'd0, Bout}, {31'd0, eb});
`ifdef SUB_OVF_EN
        check("ovf_result", {31'd0, Ovf}, {31'd0, eo});
`endif
      end else begin
        check("done_once", {31'd0, Done}, 32'd0);
        check("busy_idle", {31'd0, Busy}, 32'd0);
        check("d_keep", {24'd0, D}, {24'd0, ed});
      end
      if (e == inj) begin
        @(negedge Clk);
        Start = 1'b1; A = 8'hFF; B = 8'($urandom);
      end else if (e == inj + 1) begin
        @(negedge Clk);
        Start = 1'b0;
      end
    end
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk); #1;
    check("no_queue", {31'd0, Busy}, 32'd0);
    exp_d = ed;
    exp_b = eb;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_d = 8'h00;
    exp_b = 1'b0;
    RstN = 1'b0; Start = 1'b0; Bin = 1'b0; A = 8'h00; B = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_d", {24'd0, D}, 32'd0);
    check("rst_bout", {31'd0, Bout}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    #1 RstN = 1'b1;

    run_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 8);
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 2);
    run_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);

    // Reset asserted just before edge k+4 of an operation
    @(negedge Clk);
    Start = 1'b1; A = 8'h33; B = 8'h11; Bin = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    RstN = 1'b0;
    #1;
    check("arst_d", {24'd0, D}, 32'd0);
    check("arst_bout", {31'd0, Bout}, 32'd0);
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_done", {31'd0, Done}, 32'd0);
`ifdef SUB_OVF_EN
    check("arst_ovf", {31'd0, Ovf}, 32'd0);
`endif
    exp_d = 8'h00;
    exp_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      check("arst_no_done", {31'd0, Done}, 32'd0);
    end
    @(posedge Clk);
    #2 RstN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      check("post_rst_idle", {31'd0, Done | Busy}, 32'd0);
    end
    run_op(8'h09, 8'h02, 1'b0, 8'h07, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor8.md
SERIAL_SUBTRACTOR8 -- requirements
Module: serial_subtractor8

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 Clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 RstN  in  1  asynchronous active-low reset.
REQ-004 Start  in  1  request; sampled only in IDLE.
REQ-005 Bin  in  1  borrow-in, captured with Start.
REQ-006 A  in  8  minuend, captured with Start.
REQ-007 B  in  8  subtrahend, captured with Start.
REQ-008 Busy  out  1  high while bits are being processed.
REQ-009 Done  out  1  one-cycle pulse marking a new result.
REQ-010 D  out  8  difference, registered.
REQ-011 Bout  out  1  borrow-out, registered.
REQ-012 Ovf  out  1  signed overflow; present only with SUB_OVF_EN defined.

Function
REQ-013 Result SHALL be D = (A - B - Bin) mod 256, with Bout = 1 iff A < B + Bin (unsigned).
REQ-014 Computation SHALL be bit-serial, LSB first, one bit per clock.
REQ-015 Per bit i: d = a^b^br; br_next = (~a & b) | (~(a^b) & br); initial br = Bin.
REQ-016 The FSM SHALL have states IDLE, SHIFT and DONE, with the transitions given in REQ-017 to REQ-020.
REQ-017 IDLE: Start=1 at edge k SHALL capture A, B and Bin, clear the 3-bit bit counter, and go to SHIFT.
REQ-018 SHIFT: bit i SHALL be processed at edge k+1+i, for i = 0..7.
REQ-019 The state SHALL leave SHIFT at edge k+8, after bit 7.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE at edge k+9.
REQ-021 Busy SHALL be 1 after edges k through k+7, and 0 otherwise.
REQ-022 At edge k+8, D and Bout (and Ovf) SHALL update and Done SHALL go to 1.
REQ-023 Latency from Start to Done SHALL be 8 cycles.
REQ-024 Done SHALL be 1 for exactly one cycle.
REQ-025 D, Bout and Ovf SHALL hold the previous result throughout SHIFT, and change only at the Done edge.
REQ-026 Start in SHIFT or DONE SHALL be ignored: no capture, no queueing.
REQ-027 Changes on A, B or Bin after capture SHALL NOT affect the result in progress.
REQ-028 The bit counter SHALL wrap 7 -> 0 only together with the SHIFT -> DONE transition.

Reset
REQ-029 RstN=0 SHALL force IDLE immediately, independent of Clk.
REQ-030 RstN=0 SHALL clear the operand and borrow registers immediately, independent of Clk.
REQ-031 While RstN=0: D=0x00, Bout=0, Ovf=0, Busy=0, Done=0.
REQ-032 Reset during SHIFT SHALL abandon the operation with no Done pulse.
REQ-033 Start SHALL be accepted at the first rising edge with RstN=1.

Configuration
REQ-034 With macro SUB_OVF_EN defined: Ovf SHALL exist and equal the borrow into bit 7 XOR the borrow out of bit 7 (two's-complement overflow of A-B-Bin).
REQ-035 With SUB_OVF_EN defined: Ovf SHALL be registered with D.
REQ-036 With SUB_OVF_EN undefined: the Ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Start with A=0x50, B=0x20, Bin=0 -> Busy for 8 cycles; at edge k+8, D=0x30, Bout=0, Done pulses once.
REQ-038 A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1, Ovf=0.
REQ-039 A=0x80, B=0x01, Bin=0 -> D=0x7F, Bout=0, Ovf=1 (SUB_OVF_EN build).
REQ-040 A=0x05, B=0x05, Bin=1 -> D=0xFF, Bout=1.
REQ-041 Start A=0x10, B=0x01; then re-assert Start with A=0xFF at edge k+3 -> D=0x0F at k+8, second Start ignored.
REQ-042 RstN low at edge k+4 of an operation -> all outputs 0, no Done pulse; next Start with 0x09-0x02 -> D=0x07 after 8 cycles.
